// File: rtl/zx_video_pkg.sv
// Timing constants and shared types for the ZX81-style video generator.
// Widths match the counters they are compared against.
package zx_video_pkg;

    localparam logic [9:0] H_TOTAL        = 10'd828;
    localparam logic [9:0] H_SYNC         = 10'd64;
    localparam logic [9:0] H_START        = 10'd192;
    localparam logic [9:0] FETCH_LEAD     = 10'd32;
    localparam logic [5:0] BYTES_PER_LINE = 6'd32;
    localparam logic [8:0] V_TOTAL        = 9'd312;
    localparam logic [8:0] V_SYNC_LINES   = 9'd4;
    localparam logic [8:0] V_START        = 9'd56;
    localparam logic [8:0] V_ACTIVE       = 9'd192;
    localparam logic [3:0] PAPER          = 4'hF;
    localparam logic [3:0] INK            = 4'h0;

    localparam logic [9:0] H_FETCH  = H_START - FETCH_LEAD;
    localparam logic [9:0] H_ACTIVE = 10'd512;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_STALE
    } fetch_state_t;

    function automatic logic [3:0] luma(input logic pix, input logic inverse);
        return (pix ^ inverse) ? INK : PAPER;
    endfunction

endpackage

// File: rtl/zx_video_fetch.sv
// Display-byte fetcher: req/ack FSM, one-byte prefetch buffer and column counter.
// A request overtaken by its load tick goes STALE and its data is dropped on ack.
module zx_video_fetch
    import zx_video_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic        line_active,
    input  logic        load,
    input  logic [4:0]  load_col,
    input  logic [7:0]  row,
    input  logic        fetch_ack,
    input  logic [7:0]  fetch_data,
    output logic        fetch_req,
    output logic [12:0] fetch_addr,
    output logic [7:0]  buf_data,
    output logic        buf_vld
);

    fetch_state_t state;
    logic         line_on;
    logic [5:0]   col;
    logic [5:0]   floor_col;
    logic [5:0]   issue_col;
    logic         can_issue;

    // Never request a byte whose load tick has already passed.
    assign issue_col = (col > floor_col) ? col : floor_col;
    assign can_issue = line_on && !buf_vld && (issue_col < BYTES_PER_LINE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= F_IDLE;
            fetch_req  <= 1'b0;
            fetch_addr <= 13'd0;
            buf_data   <= 8'h00;
            buf_vld    <= 1'b0;
            col        <= 6'd0;
            floor_col  <= 6'd0;
            line_on    <= 1'b0;
        end else begin
            if (line_start) begin
                line_on   <= line_active;
                col       <= 6'd0;
                floor_col <= 6'd0;
                buf_vld   <= 1'b0;
            end
            if (load) begin
                buf_vld   <= 1'b0;
                floor_col <= {1'b0, load_col} + 6'd1;
            end

            case (state)
                F_IDLE: begin
                    if (line_start) begin
                        if (line_active) begin
                            fetch_req  <= 1'b1;
                            fetch_addr <= {row, 5'd0};
                            state      <= F_REQ;
                        end
                    end else if (can_issue) begin
                        fetch_req  <= 1'b1;
                        fetch_addr <= {row, issue_col[4:0]};
                        col        <= issue_col;
                        state      <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (fetch_ack) begin
                        fetch_req <= 1'b0;
                        state     <= F_IDLE;
                        if (!line_start) col <= col + 6'd1;
                        // An ack coinciding with the load tick is late.
                        if (!load && !line_start) begin
                            buf_data <= fetch_data;
                            buf_vld  <= 1'b1;
                        end
                    end else if (load) begin
                        state <= F_STALE;
                        col   <= col + 6'd1;
                    end else if (line_start) begin
                        state <= F_STALE;
                    end
                end
                F_STALE: begin
                    if (fetch_ack) begin
                        fetch_req <= 1'b0;
                        state     <= F_IDLE;
                    end
                end
                default: begin
                    fetch_req <= 1'b0;
                    state     <= F_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/zx_video_gen.sv
// ZX81-style video source: line/frame counters, composite sync, 1 bpp pixel
// shifter and sticky underrun flag. Outputs lag the counters by one ce_2pix.
module zx_video_gen
    import zx_video_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_2pix,
    input  logic        inv,
    output logic        fetch_req,
    output logic [12:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [7:0]  fetch_data,
    output logic        csync,
    output logic [3:0]  v_out,
    output logic        underrun
);

    logic [9:0] h_cnt;
    logic [8:0] v_cnt;
    logic [9:0] h_off;
    logic [8:0] v_off;
    logic       h_act;
    logic       v_act;
    logic       sync_n;
    logic       load_tick;
    logic [7:0] sreg;
    logic       sinv;
    logic [7:0] buf_data;
    logic       buf_vld;
    logic [7:0] pix_byte;
    logic       pix_inv;

    // Offsets wrap below the window start, so one compare covers both edges.
    assign h_off     = h_cnt - H_START;
    assign v_off     = v_cnt - V_START;
    assign h_act     = h_off < H_ACTIVE;
    assign v_act     = v_off < V_ACTIVE;
    assign sync_n    = !((v_cnt < V_SYNC_LINES) || (h_cnt < H_SYNC));
    assign load_tick = v_act && h_act && (h_off[3:0] == 4'd0);

    always_comb begin
        pix_byte = sreg;
        pix_inv  = sinv;
        if (load_tick) begin
            pix_byte = buf_vld ? buf_data : 8'h00;
            pix_inv  = inv;
        end
    end

    zx_video_fetch u_fetch (
        .clk         (clk),
        .reset       (reset),
        .line_start  (ce_2pix && (h_cnt == H_FETCH)),
        .line_active (v_act),
        .load        (ce_2pix && load_tick),
        .load_col    (h_off[8:4]),
        .row         (v_off[7:0]),
        .fetch_ack   (fetch_ack),
        .fetch_data  (fetch_data),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .buf_data    (buf_data),
        .buf_vld     (buf_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt    <= 10'd0;
            v_cnt    <= 9'd0;
            csync    <= 1'b1;
            v_out    <= 4'h0;
            underrun <= 1'b0;
            sreg     <= 8'h00;
            sinv     <= 1'b0;
        end else if (ce_2pix) begin
            csync <= sync_n;
            if (v_act && h_act)
                v_out <= luma(pix_byte[7], pix_inv);
            else if (!sync_n)
                v_out <= 4'h0;
            else
                v_out <= PAPER;

            // Each pixel lasts two ticks; shift after the second one.
            if (load_tick) begin
                sreg <= pix_byte;
                sinv <= inv;
                if (!buf_vld) underrun <= 1'b1;
            end else if (h_off[0]) begin
                sreg <= {sreg[6:0], 1'b0};
            end

            if (h_cnt == H_TOTAL - 10'd1) begin
                h_cnt <= 10'd0;
                v_cnt <= (v_cnt == V_TOTAL - 9'd1) ? 9'd0 : v_cnt + 9'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

endmodule
